max_pool_ctrl: RTL and testbench

Sequencer that drives one 2x2 max-pool datapath unit across a whole stored feature map. On `start` it walks every channel and every non-overlapping 2x2 window of an `IN_H` x `IN_W` map held in a single-read synchronous RAM. It hands the four window values to the pool unit, captures the pooled result, and writes it to the output RAM. It sits between the conv-layer output buffer and the next layer's input buffer, e.g. the C1->S2 and C3->S4 stages.

---
 rtl/max_pool_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_max_pool_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_ctrl.sv
// Sequencer for one 2x2 max-pool unit: walks every channel and window of a stored map,
// feeds the pool unit and writes the pooled results. Define MAX_POOL_CTRL_RELU_EN for fused ReLU.
module max_pool_ctrl #(
  parameter int BITWIDTH = 17,
  parameter int IN_W     = 28,
  parameter int IN_H     = 28,
  parameter int CHANNELS = 6,
  parameter int ADDR_W   = 13
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_en,
  output logic [ADDR_W-1:0]            rd_addr,
  input  logic signed [BITWIDTH-1:0]   rd_data,
  output logic signed [BITWIDTH-1:0]   pool_a,
  output logic signed [BITWIDTH-1:0]   pool_b,
  output logic signed [BITWIDTH-1:0]   pool_c,
  output logic signed [BITWIDTH-1:0]   pool_d,
  output logic                         pool_valid,
  input  logic signed [2*BITWIDTH-1:0] pool_result,
  input  logic                         pool_result_valid,
  output logic                         wr_en,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic signed [BITWIDTH-1:0]   wr_data
);

  localparam int OUT_W = IN_W / 2;
  localparam int OUT_H = IN_H / 2;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  // Moving to the next row pair or to the next channel is the same address jump.
  localparam logic [ADDR_W-1:0] STEP_COL = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] STEP_ROW = ADDR_W'(IN_W + 2);
  localparam logic [ADDR_W-1:0] ROW_OFS  = ADDR_W'(IN_W);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_RD0   = 4'd1;
  localparam logic [3:0] S_RD1   = 4'd2;
  localparam logic [3:0] S_RD2   = 4'd3;
  localparam logic [3:0] S_RD3   = 4'd4;
  localparam logic [3:0] S_CAPT  = 4'd5;
  localparam logic [3:0] S_ISSUE = 4'd6;
  localparam logic [3:0] S_WAIT  = 4'd7;
  localparam logic [3:0] S_WRITE = 4'd8;
  localparam logic [3:0] S_FIN   = 4'd9;

  logic [3:0]                 state_q, state_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [ROW_W-1:0]           orow_q, orow_d;
  logic [COL_W-1:0]           ocol_q, ocol_d;
  logic [ADDR_W-1:0]          win_q, win_d;
  logic [ADDR_W-1:0]          oidx_q, oidx_d;
  logic signed [BITWIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;

  logic                       busy_q, done_q, rd_en_q, pool_valid_q, wr_en_q;
  logic [ADDR_W-1:0]          rd_addr_q, rd_addr_d, wr_addr_q;
  logic signed [BITWIDTH-1:0] pool_a_q, pool_b_q, pool_c_q, pool_d_q, wr_data_q;

  logic                       last_col, last_row, last_ch;
  logic signed [BITWIDTH-1:0] result_trunc;
  logic                       unused_result_hi;

  assign last_col = (ocol_q == COL_W'(OUT_W - 1));
  assign last_row = (orow_q == ROW_W'(OUT_H - 1));
  assign last_ch  = (ch_q == CH_W'(CHANNELS - 1));

`ifdef MAX_POOL_CTRL_RELU_EN
  assign result_trunc = pool_result[2*BITWIDTH-1] ? '0 : pool_result[BITWIDTH-1:0];
`else
  assign result_trunc = pool_result[BITWIDTH-1:0];
`endif
  // The max of BITWIDTH-bit samples never needs the upper half.
  assign unused_result_hi = ^pool_result[2*BITWIDTH-1:BITWIDTH];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    ch_d    = ch_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    win_d   = win_q;
    oidx_d  = oidx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RD0;
        ch_d    = '0;
        orow_d  = '0;
        ocol_d  = '0;
        win_d   = '0;
        oidx_d  = '0;
      end
      S_RD0:   state_d = S_RD1;
      S_RD1: begin a_d = rd_data; state_d = S_RD2; end
      S_RD2: begin b_d = rd_data; state_d = S_RD3; end
      S_RD3: begin c_d = rd_data; state_d = S_CAPT; end
      S_CAPT:  state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (pool_result_valid) state_d = S_WRITE;
      S_WRITE: begin
        oidx_d = oidx_q + ADDR_W'(1);
        win_d  = win_q + (last_col ? STEP_ROW : STEP_COL);
        if (!last_col) begin
          ocol_d = ocol_q + COL_W'(1);
        end else begin
          ocol_d = '0;
          if (!last_row) begin
            orow_d = orow_q + ROW_W'(1);
          end else begin
            orow_d = '0;
            ch_d   = last_ch ? '0 : ch_q + CH_W'(1);
          end
        end
        state_d = (last_col && last_row && last_ch) ? S_FIN : S_RD0;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_addr_d = rd_addr_q;
    case (state_d)
      S_RD0:   rd_addr_d = win_d;
      S_RD1:   rd_addr_d = win_d + ADDR_W'(1);
      S_RD2:   rd_addr_d = win_d + ROW_OFS;
      S_RD3:   rd_addr_d = win_d + ROW_OFS + ADDR_W'(1);
      default: ;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up with its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ch_q         <= '0;
      orow_q       <= '0;
      ocol_q       <= '0;
      win_q        <= '0;
      oidx_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      pool_a_q     <= '0;
      pool_b_q     <= '0;
      pool_c_q     <= '0;
      pool_d_q     <= '0;
      pool_valid_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      ch_q         <= ch_d;
      orow_q       <= orow_d;
      ocol_q       <= ocol_d;
      win_q        <= win_d;
      oidx_q       <= oidx_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      busy_q       <= (state_d != S_IDLE) && (state_d != S_FIN);
      done_q       <= (state_d == S_FIN);
      rd_en_q      <= (state_d >= S_RD0) && (state_d <= S_RD3);
      rd_addr_q    <= rd_addr_d;
      pool_valid_q <= (state_d == S_ISSUE);
      wr_en_q      <= (state_d == S_WRITE);
      if (state_q == S_CAPT) begin
        pool_a_q <= a_q;
        pool_b_q <= b_q;
        pool_c_q <= c_q;
        pool_d_q <= rd_data;
      end
      if (state_d == S_WRITE) begin
        wr_addr_q <= oidx_q;
        wr_data_q <= result_trunc;
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign pool_a     = pool_a_q;
  assign pool_b     = pool_b_q;
  assign pool_c     = pool_c_q;
  assign pool_d     = pool_d_q;
  assign pool_valid = pool_valid_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_max_pool_ctrl.sv
// Randomized bench for max_pool_ctrl: RAM and pool-unit models, golden max per window.
module tb_max_pool_ctrl;

  localparam int BW   = 17;
  localparam int W    = 28;
  localparam int H    = 28;
  localparam int CH   = 6;
  localparam int AW   = 13;
  localparam int NIN  = CH * W * H;
  localparam int NWIN = CH * (W / 2) * (H / 2);
`ifdef MAX_POOL_CTRL_RELU_EN
  localparam logic [BW-1:0] EXP_W0 = '0;
`else
  localparam logic [BW-1:0] EXP_W0 = '1;
`endif

  logic                   clk, reset, start;
  logic                   busy, done, rd_en, pool_valid, wr_en, pool_result_valid;
  logic [AW-1:0]          rd_addr, wr_addr;
  logic signed [BW-1:0]   rd_data, pool_a, pool_b, pool_c, pool_d, wr_data;
  logic signed [2*BW-1:0] pool_result;

  max_pool_ctrl #(
    .BITWIDTH(BW), .IN_W(W), .IN_H(H), .CHANNELS(CH), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pool_a(pool_a), .pool_b(pool_b), .pool_c(pool_c), .pool_d(pool_d),
    .pool_valid(pool_valid), .pool_result(pool_result),
    .pool_result_valid(pool_result_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, t0 = 0, done_cyc = 0;
  int busy_cnt, done_cnt, win_idx, wr_idx, period_err, period, last_wr_cyc;
  logic [AW-1:0] last_wr_addr;
  logic [BW-1:0] first_wr_data;
  int pool_lat = 1;
  bit spur_en = 1'b0;

  logic signed [BW-1:0] mem [NIN];
  logic [BW-1:0]        exp_out [NWIN];
  logic [4*BW-1:0]      exp_win [NWIN];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic signed [BW-1:0] max4(input logic signed [BW-1:0] a, b, c, d);
    logic signed [BW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic [127:0] outs();
    return {busy, done, rd_en, rd_addr, pool_a, pool_b, pool_c, pool_d,
            pool_valid, wr_en, wr_addr, wr_data};
  endfunction

  // Synchronous single-read RAM: data one cycle after rd_en.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Pool unit with configurable latency, plus an optional stray valid during RD1.
  logic signed [2*BW-1:0] held;
  int lat_cnt;
  logic rd_en_prev;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pool_result_valid <= 1'b0;
      pool_result       <= '0;
      held              <= '0;
      lat_cnt           <= 0;
      rd_en_prev        <= 1'b0;
    end else begin
      logic signed [BW-1:0] m;
      pool_result_valid <= 1'b0;
      if (lat_cnt != 0) begin
        lat_cnt <= lat_cnt - 1;
        if (lat_cnt == 1) begin
          pool_result_valid <= 1'b1;
          pool_result       <= held;
        end
      end
      if (pool_valid) begin
        m = max4(pool_a, pool_b, pool_c, pool_d);
        if (pool_lat == 1) begin
          pool_result_valid <= 1'b1;
          pool_result       <= {{BW{m[BW-1]}}, m};
        end else begin
          held    <= {{BW{m[BW-1]}}, m};
          lat_cnt <= pool_lat - 1;
        end
      end
      if (spur_en && rd_en && !rd_en_prev) begin
        pool_result_valid <= 1'b1;
        pool_result       <= 34'sd12345;
      end
      rd_en_prev <= rd_en;
    end
  end

  always @(posedge clk) cyc++;

  // Scoreboard: every window issued and every write is compared with the golden model.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cnt++;
      if (done) begin
        if (done_cnt == 0) done_cyc = cyc;
        done_cnt++;
      end
      if (pool_valid) begin
        if (win_idx < NWIN) check("pool_window", {pool_a, pool_b, pool_c, pool_d}, exp_win[win_idx]);
        else check("pool_extra", win_idx, NWIN - 1);
        win_idx++;
      end
      if (wr_en) begin
        if (wr_idx < NWIN) begin
          check("wr_addr", wr_addr, wr_idx);
          check("wr_data", $unsigned(wr_data), exp_out[wr_idx]);
        end else begin
          check("wr_extra", wr_idx, NWIN - 1);
        end
        if (wr_idx > 0 && cyc - last_wr_cyc != period) period_err++;
        if (wr_idx == 0) first_wr_data = wr_data;
        last_wr_cyc  = cyc;
        last_wr_addr = wr_addr;
        wr_idx++;
      end
    end
  end

  task automatic fill_mem(input bit plant);
    for (int i = 0; i < NIN; i++) mem[i] = BW'($urandom);
    if (plant) begin
      mem[0]     = BW'(-3);
      mem[1]     = BW'(-9);
      mem[W]     = BW'(-1);
      mem[W + 1] = BW'(-20);
    end
    for (int ch = 0; ch < CH; ch++)
      for (int r = 0; r < H / 2; r++)
        for (int c = 0; c < W / 2; c++) begin
          int base, idx;
          logic signed [BW-1:0] m;
          base = ch * W * H + 2 * r * W + 2 * c;
          idx  = (ch * (H / 2) + r) * (W / 2) + c;
          m    = max4(mem[base], mem[base + 1], mem[base + W], mem[base + W + 1]);
`ifdef MAX_POOL_CTRL_RELU_EN
          if (m < 0) m = '0;
`endif
          exp_out[idx] = m;
          exp_win[idx] = {mem[base], mem[base + 1], mem[base + W], mem[base + W + 1]};
        end
  endtask

  task automatic clear_stats();
    busy_cnt = 0; done_cnt = 0; win_idx = 0; wr_idx = 0; period_err = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
    check("done_seen", done_cnt != 0, 1);
  endtask

  // Span counts the start cycle and the done cycle: 8 (or 7+lat) per window plus 2.
  task automatic run_pass(input int lat, input bit spur, input bit plant, input bit repulse);
    pool_lat = lat;
    spur_en  = spur;
    period   = 7 + lat;
    fill_mem(plant);
    clear_stats();
    pulse_start();
    if (repulse) fork
      begin
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join_none
    wait_done(12 * NWIN + 100);
    repeat (4) @(negedge clk);
    check("write_count", wr_idx, NWIN);
    check("window_count", win_idx, NWIN);
    check("last_wr_addr", last_wr_addr, NWIN - 1);
    check("pass_span", done_cyc - t0 + 1, period * NWIN + 2);
    check("busy_cycles", busy_cnt, period * NWIN);
    check("done_pulses", done_cnt, 1);
    check("write_period", period_err, 0);
    check("busy_after_done", busy, 0);
    if (plant) check("neg_window", first_wr_data, EXP_W0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear_stats();
    period = 8;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", outs(), 0);

    run_pass(1, 1'b0, 1'b1, 1'b0);
    run_pass(3, 1'b1, 1'b0, 1'b1);

    // Abort during window 5 (its RD2 reads row 1, column 10).
    pool_lat = 1;
    spur_en  = 1'b0;
    period   = 8;
    fill_mem(1'b0);
    clear_stats();
    pulse_start();
    for (int i = 0; i < 400 && !(rd_en && rd_addr == AW'(10 + W)); i++) @(negedge clk);
    check("reach_window5", {rd_en, rd_addr}, {1'b1, AW'(10 + W)});
    check("writes_before_abort", wr_idx, 5);
    reset = 1'b1;
    #1;
    check("abort_outputs", outs(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("no_done_after_abort", done_cnt, 0);
    check("idle_after_abort", busy, 0);
    clear_stats();
    pulse_start();
    check("restart_addr", {rd_en, rd_addr}, {1'b1, AW'(0)});
    wait_done(12 * NWIN + 100);
    repeat (4) @(negedge clk);
    check("restart_writes", wr_idx, NWIN);
    check("restart_span", done_cyc - t0 + 1, 8 * NWIN + 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
